// File: rtl/cpu_regfile.sv
// cpu_regfile: 2R1W register file with a hard-wired zero register and same-cycle write-to-read forwarding.
module cpu_regfile #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic              wr_ack
);
    logic [DATA_W-1:0] regs [2**ADDR_W];
    logic              commit;
    logic              fwd_a, fwd_b;
    assign commit = we && !(ZERO_REG && waddr == '0);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**ADDR_W; i++) regs[i] <= '0;
            wr_ack <= 1'b0;
        end else begin
            wr_ack <= commit;
            if (commit) regs[waddr] <= wdata;
        end
    end
    // Forwarding is gated by rst_n so reads stay zero while the array is held cleared.
    assign fwd_a = BYPASS && we && rst_n && raddr_a == waddr;
    assign fwd_b = BYPASS && we && rst_n && raddr_b == waddr;
    always_comb begin
        rdata_a = (ZERO_REG && raddr_a == '0) ? '0 : fwd_a ? wdata : regs[raddr_a];
        rdata_b = (ZERO_REG && raddr_b == '0) ? '0 : fwd_b ? wdata : regs[raddr_b];
    end
endmodule

// File: tb/tb_cpu_regfile.sv
// tb_cpu_regfile: directed test of cpu_regfile with bypassing and non-bypassing instances checked against an array model.
module tb_cpu_regfile;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       we = 1'b0;
    logic [2:0] waddr = '0, raddr_a = '0, raddr_b = '0;
    logic [7:0] wdata = '0;
    logic [7:0] ra1, rb1, ra0, rb0;
    logic       ack1, ack0;
    int         n_tests = 0, n_fail = 0;
    logic [7:0] mem [8] = '{default: 8'h00};
    logic       ack_m = 1'b0;

    cpu_regfile #(.BYPASS(1'b1)) u_byp (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra1), .rdata_b(rb1), .wr_ack(ack1));
    cpu_regfile #(.BYPASS(1'b0)) u_nob (.clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(ra0), .rdata_b(rb0), .wr_ack(ack0));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: register 0 is never stored, writes commit only out of reset.
    always @(posedge clk) begin
        ack_m = rst_n && we && waddr != 3'd0;
        if (ack_m) mem[waddr] = wdata;
    end
    always @(negedge rst_n) begin
        foreach (mem[i]) mem[i] = 8'h00;
        ack_m = 1'b0;
    end

    function automatic logic [7:0] exp_rd(input logic [2:0] a, input bit byp);
        if (a == 3'd0) return 8'h00;
        if (byp && we && rst_n && a == waddr) return wdata;
        return mem[a];
    endfunction

    always @(negedge clk) begin
        chk("cyc byp rdata_a", ra1, exp_rd(raddr_a, 1'b1));
        chk("cyc byp rdata_b", rb1, exp_rd(raddr_b, 1'b1));
        chk("cyc nob rdata_a", ra0, exp_rd(raddr_a, 1'b0));
        chk("cyc nob rdata_b", rb0, exp_rd(raddr_b, 1'b0));
        chk("cyc byp wr_ack", ack1, ack_m);
        chk("cyc nob wr_ack", ack0, ack_m);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12 rst_n = 1'b1;
        step();
        chk("reset rdata_a", ra1, 8'h00);
        chk("reset wr_ack", ack1, 1'b0);
        // asynchronous reset clear
        we = 1'b1; waddr = 3'd3; wdata = 8'hA5; raddr_a = 3'd3;
        step();
        we = 1'b0;
        chk("r3 written", ra1, 8'hA5);
        chk("r3 ack", ack1, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async clr rdata_a", ra1, 8'h00);
        chk("async clr nob rdata_a", ra0, 8'h00);
        chk("async clr wr_ack", ack1, 1'b0);
        #3 rst_n = 1'b1;
        step();
        chk("post reset rdata_a", ra1, 8'h00);
        chk("post reset wr_ack", ack1, 1'b0);
        // back-to-back writes
        we = 1'b1; waddr = 3'd1; wdata = 8'h0F;
        step();
        chk("ack first", ack1, 1'b1);
        waddr = 3'd2; wdata = 8'hF0;
        step();
        we = 1'b0;
        chk("ack second", ack1, 1'b1);
        raddr_a = 3'd1; raddr_b = 3'd2;
        #1;
        chk("r1", ra1, 8'h0F);
        chk("r2", rb1, 8'hF0);
        chk("or", ra1 | rb1, 8'hFF);
        chk("and", ra1 & rb1, 8'h00);
        step();
        chk("ack drop", ack1, 1'b0);
        // zero register
        we = 1'b1; waddr = 3'd0; wdata = 8'h77; raddr_a = 3'd0; raddr_b = 3'd0;
        #1;
        chk("zero pre a", ra1, 8'h00);
        chk("zero pre b", rb1, 8'h00);
        step();
        we = 1'b0;
        chk("zero post a", ra1, 8'h00);
        chk("zero post b", rb0, 8'h00);
        chk("zero ack", ack1, 1'b0);
        // bypass vs no bypass
        we = 1'b1; waddr = 3'd4; wdata = 8'h11;
        step();
        wdata = 8'h22; raddr_a = 3'd4; raddr_b = 3'd4;
        #1;
        chk("byp pre a", ra1, 8'h22);
        chk("byp pre b", rb1, 8'h22);
        chk("nob pre a", ra0, 8'h11);
        chk("nob pre b", rb0, 8'h11);
        step();
        we = 1'b0;
        chk("nob post a", ra0, 8'h22);
        chk("byp post b", rb1, 8'h22);
        // write disable
        waddr = 3'd5; wdata = 8'hFF; raddr_a = 3'd5;
        repeat (3) step();
        chk("we0 r5", ra1, 8'h00);
        chk("we0 ack", ack1, 1'b0);
        // full sweep
        for (int i = 1; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = 8'(i * 8'h11);
            step();
        end
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 3'(i); raddr_b = 3'(7 - i);
            #1;
            chk("sweep a", ra1, 8'(i * 8'h11));
            chk("sweep b", rb0, 8'((7 - i) * 8'h11));
        end
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
